// File: rtl/switch_debouncer_if.sv
// -----------------------------------------------------------------------------
// switch_debouncer_if
// Groups the switch-conditioning signals between the raw DIP-switch source and
// the debouncer.
//   sw_in        raw asynchronous switch levels (driven by the source side)
//   sw_out       debounced, committed switch vector
//   sw_valid     high once a first value has been committed since reset
//   sw_changed   one-cycle pulse when sw_out takes a new, different value
//   changed_mask bits that flipped in that commit; zero when sw_changed=0
// modport master: the switch source / consumer side
// modport slave : the debouncer itself
// -----------------------------------------------------------------------------
interface switch_debouncer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_out;
    logic             sw_valid;
    logic             sw_changed;
    logic [WIDTH-1:0] changed_mask;

    modport master (
        output sw_in,
        input  sw_out,
        input  sw_valid,
        input  sw_changed,
        input  changed_mask
    );

    modport slave (
        input  sw_in,
        output sw_out,
        output sw_valid,
        output sw_changed,
        output changed_mask
    );
endinterface

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
// Conditions the board DIP switches before they reach the CPU DIn port.
// The raw vector is brought into the clk domain through a 2-FF synchroniser,
// then a new value is committed only after the whole synchronised vector has
// been stable for STABLE_CYCLES consecutive cycles. Each committed change
// raises a one-cycle sw_changed pulse together with the mask of flipped bits.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high; clears every register
//   sw_if  slave modport: sw_in in; sw_out, sw_valid, sw_changed,
//          changed_mask out
// -----------------------------------------------------------------------------
module switch_debouncer #(
    parameter int WIDTH         = 32,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    switch_debouncer_if.slave   sw_if
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sw_out_q, sw_out_d;
    logic             sw_valid_q, sw_valid_d;
    logic             sw_changed_q, sw_changed_d;
    logic [WIDTH-1:0] changed_mask_q, changed_mask_d;

    always_comb begin
        // Only sync1 samples the asynchronous input; everything else uses sync2.
        sync1_d        = sw_if.sw_in;
        sync2_d        = sync1_q;
        cand_d         = cand_q;
        cnt_d          = cnt_q;
        sw_out_d       = sw_out_q;
        sw_valid_d     = sw_valid_q;
        sw_changed_d   = 1'b0;
        changed_mask_d = '0;

        if (sync2_q != cand_q) begin
            // Any bit moving restarts the window for the whole vector.
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q < CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            // Commit point; cnt saturates here so a held input never re-pulses.
            sw_valid_d = 1'b1;
            if (cand_q != sw_out_q) begin
                sw_out_d       = cand_q;
                changed_mask_d = cand_q ^ sw_out_q;
                sw_changed_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            cand_q         <= '0;
            cnt_q          <= '0;
            sw_out_q       <= '0;
            sw_valid_q     <= 1'b0;
            sw_changed_q   <= 1'b0;
            changed_mask_q <= '0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            cand_q         <= cand_d;
            cnt_q          <= cnt_d;
            sw_out_q       <= sw_out_d;
            sw_valid_q     <= sw_valid_d;
            sw_changed_q   <= sw_changed_d;
            changed_mask_q <= changed_mask_d;
        end
    end

    assign sw_if.sw_out       = sw_out_q;
    assign sw_if.sw_valid     = sw_valid_q;
    assign sw_if.sw_changed   = sw_changed_q;
    assign sw_if.changed_mask = changed_mask_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
// Directed scenarios followed by randomized switch activity. A reference model
// keeps the history of sampled switch values and commits a value once the
// synchronised stream (input delayed two edges) has held it over the last
// STABLE_CYCLES+1 samples. Expected change events go into a scoreboard queue
// that a separate negedge monitor pops whenever the DUT pulses sw_changed.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;
    localparam int W = 32;
    localparam int S = 4;

    typedef struct {
        bit         brk;
        logic [W-1:0] v;
    } samp_t;

    typedef struct {
        logic [W-1:0] out;
        logic [W-1:0] mask;
    } change_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   mon_en = 1'b0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    samp_t   hist[$];
    change_t sbq[$];

    logic [W-1:0] m_out = '0;
    logic         m_valid = 1'b0;
    logic         m_changed = 1'b0;

    switch_debouncer_if #(.WIDTH(W)) bus ();

    switch_debouncer #(
        .WIDTH(W),
        .STABLE_CYCLES(S)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sw_if(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reset leaves the synchronised stream looking like three zero samples
    // that directly follow a change, so the window starts from scratch.
    function automatic void model_reset();
        samp_t s;
        hist.delete();
        s.brk = 1'b1; s.v = '0;
        hist.push_back(s);
        s.brk = 1'b0;
        repeat (3) hist.push_back(s);
        sbq.delete();
    endfunction

    // Returns 1 when the value two samples back has been constant across the
    // last S+1 synchronised samples; that value is returned in val.
    function automatic bit model_stable(input logic [W-1:0] now, output logic [W-1:0] val);
        samp_t s;
        int    last;
        bit    ok;
        s.brk = 1'b0; s.v = now;
        hist.push_back(s);
        if (hist.size() > 64) void'(hist.pop_front());
        last = hist.size() - 1;
        val  = '0;
        if (hist.size() < S + 3) return 1'b0;
        val = hist[last-2].v;
        ok  = 1'b1;
        for (int k = 0; k <= S; k++) begin
            if (hist[last-2-k].brk || hist[last-2-k].v !== val) ok = 1'b0;
        end
        return ok;
    endfunction

    always @(posedge clk) begin
        logic [W-1:0] v;
        change_t      c;
        if (reset) begin
            model_reset();
            m_out     <= '0;
            m_valid   <= 1'b0;
            m_changed <= 1'b0;
        end else if (model_stable(bus.sw_in, v)) begin
            m_valid <= 1'b1;
            if (v !== m_out) begin
                c.out = v; c.mask = v ^ m_out;
                sbq.push_back(c);
                m_out     <= v;
                m_changed <= 1'b1;
            end else begin
                m_changed <= 1'b0;
            end
        end else begin
            m_changed <= 1'b0;
        end
    end

    // Monitor: compare outputs each cycle and pop the scoreboard on each pulse.
    always @(negedge clk) begin
        change_t c;
        if (mon_en) begin
            chk("sw_out", bus.sw_out, m_out);
            chk("sw_valid", W'(bus.sw_valid), W'(m_valid));
            chk("sw_changed", W'(bus.sw_changed), W'(m_changed));
            if (bus.sw_changed === 1'b1) begin
                pulses++;
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected: pulse with mask %h, none expected", bus.changed_mask);
                end else begin
                    c = sbq.pop_front();
                    chk("sb_out", bus.sw_out, c.out);
                    chk("sb_mask", bus.changed_mask, c.mask);
                end
            end else begin
                chk("mask_idle", bus.changed_mask, '0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts edges from the stimulus change (first edge = 1) until a pulse
    // (want_pulse) or sw_valid is seen.
    task automatic measure(input string name, input int exp_edges, input bit want_pulse,
                           input logic [W-1:0] exp_mask);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (want_pulse ? (bus.sw_changed === 1'b1) : (bus.sw_valid === 1'b1)) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no event within 40 edges", name);
        end else begin
            chk({name, "_latency"}, W'(n), W'(exp_edges));
            if (want_pulse) chk({name, "_mask"}, bus.changed_mask, exp_mask);
        end
    endtask

    initial begin
        int base;
        logic [W-1:0] v;

        // Reset behaviour
        bus.sw_in = 32'h19071110;
        reset = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        cyc(2);
        chk("rst_out", bus.sw_out, '0);
        chk("rst_valid", W'(bus.sw_valid), '0);
        chk("rst_mask", bus.changed_mask, '0);
        reset = 1'b0;
        measure("rst_commit", 7, 1'b1, 32'h19071110);
        chk("rst_valid_up", W'(bus.sw_valid), W'(1));
        cyc(3);

        // Step change
        bus.sw_in = 32'h19061110;
        measure("step", 7, 1'b1, 32'h00010000);
        @(negedge clk);
        chk("step_pulse_end", W'(bus.sw_changed), '0);
        cyc(3);

        // Glitch rejection
        base = pulses;
        bus.sw_in[0] = 1'b1;
        cyc(2);
        bus.sw_in[0] = 1'b0;
        cyc(20);
        chk("glitch_pulses", W'(pulses - base), '0);
        chk("glitch_out", bus.sw_out, 32'h19061110);

        // Continuous bounce on bit 31, then hold high
        base = pulses;
        repeat (10) begin
            bus.sw_in[31] = ~bus.sw_in[31];
            cyc(3);
        end
        chk("bounce_pulses", W'(pulses - base), '0);
        bus.sw_in[31] = 1'b1;
        measure("bounce", 7, 1'b1, 32'h80000000);
        cyc(3);

        // Reset mid-window
        bus.sw_in = 32'hA5A50F0F;
        cyc(2);
        reset = 1'b1;
        cyc(2);
        chk("midrst_valid", W'(bus.sw_valid), '0);
        chk("midrst_out", bus.sw_out, '0);
        reset = 1'b0;
        measure("midrst", 7, 1'b1, 32'hA5A50F0F);
        cyc(3);

        // Zero input at release: candidate already matches, window starts at once
        bus.sw_in = '0;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        base = pulses;
        measure("zero_valid", 4, 1'b0, '0);
        cyc(5);
        chk("zero_pulses", W'(pulses - base), '0);
        chk("zero_valid_hold", W'(bus.sw_valid), W'(1));

        // Randomized activity
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0: begin
                    reset = 1'b1;
                    cyc($urandom_range(1, 2));
                    reset = 1'b0;
                end
                1, 2, 3: begin
                    v = $urandom();
                    bus.sw_in = v;
                end
                default: begin
                    v = bus.sw_in;
                    v[$urandom_range(0, W-1)] ^= 1'b1;
                    bus.sw_in = v;
                end
            endcase
            cyc($urandom_range(1, 10));
        end
        cyc(12);
        chk("sb_drained", W'(sbq.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
